pipe_memory_request: RTL and testbench
======================================

# pipe_memory_request

Memory-access initiator for the ExperiarCore pipeline. It takes a load or store from the execute stage, generates the byte-lane select, and for stores shifts the data into the correct lanes. It then runs a single outstanding request on the core data bus and stalls the pipe until the bus acknowledges. Captured load words are handed on raw; the writeback stage does the lane extraction and sign extension.

## Interface
- `TIMEOUT_CYCLES`, default 255: ACTIVE cycles before a request is abandoned. 8-bit value, must be ≥1. Used only when the timeout feature is compiled in.
- `clk`  in  1  core clock; everything is sampled on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `requestValid`  in  1  the execute stage presents a memory op.
- `requestIsStore`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RISC-V load/store funct3. Size comes from bits [1:0]: 00 = byte, 01 = half, 10 = word.
- `address`  in  32  effective byte address.
- `storeData`  in  32  rs2 value, right-aligned.
- `currentPipeStall`  out  1  hold the pipe.
- `requestDone`  out  1  one-cycle pulse when the request completes.
- `addressMisaligned`  out  1  one-cycle pulse when a request is rejected as misaligned.
- `busError`  out  1  one-cycle pulse on timeout.
- `loadData`  out  32  raw bus word from the last completed load.
- `memoryEnable`  out  1  bus request.
- `memoryWriteEnable`  out  1  1 = write.
- `memoryAddress`  out  32  word address: `{address[31:2], 2'b00}`.
- `memoryByteSelect`  out  4  active byte lanes.
- `memoryDataWrite`  out  32  lane-aligned store data.
- `memoryReady`  in  1  bus acknowledge; valid only while `memoryEnable` is high.
- `memoryDataRead`  in  32  bus read data, valid with `memoryReady` on loads.

## Operation
- States: IDLE, ACTIVE, DONE. Reset state is IDLE.
- Base byte mask from `funct3[1:0]`:
  - 00 → 0001
  - 01 → 0011
  - 10 → 1111
  - 11 → 0000, treated as misaligned.
- The mask is shifted into 7 bits: `{3'b0, base} << address[1:0]`.
  - Misaligned when any of bits [6:4] is set, or when the base mask is 0000.
  - Otherwise `memoryByteSelect` = bits [3:0].
- Store data placement: `storeData << (8*address[1:0])`.
  - Byte: source is `storeData[7:0]`.
  - Half: source is `storeData[15:0]`.
  - Lanes outside the select are driven 0.
- IDLE, `requestValid` high and aligned: latch the bus outputs, assert `memoryEnable`, go to ACTIVE.
- IDLE, `requestValid` high and misaligned:
  - Pulse `addressMisaligned` the next cycle.
  - Issue no bus cycle and stay in IDLE.
  - The request is dropped; the pipe is responsible for the trap.
- ACTIVE:
  - All bus outputs are held stable.
  - On `memoryReady`: drop `memoryEnable` and go to DONE. For loads, also capture `memoryDataRead` into `loadData`.
- DONE:
  - `requestDone` is high for exactly this cycle and `requestValid` is ignored.
  - Always returns to IDLE on the next edge.
- `currentPipeStall` = (state == ACTIVE) || (state == IDLE && `requestValid` && aligned). It is combinational.
- `loadData` holds its value until the next load completes; stores do not modify it.

## Timing
- Reset values:
  - All outputs are 0.
  - `loadData` = 0 and state = IDLE.
  - Assertion is asynchronous: `memoryEnable` drops immediately, even mid-ACTIVE.
- Accept on edge N → `memoryEnable` is high in cycle N+1.
- `memoryReady` high in cycle M → `memoryEnable` is low and `requestDone` is high in cycle M+1 → IDLE in M+2.
- Minimum latency is 2 cycles from accept to `requestDone` (zero-wait bus). Back-to-back requests: a new accept is possible at the end of M+2.
- `memoryReady` outside ACTIVE is ignored.
- A misalignment pulse occurs one cycle after the presenting cycle. `currentPipeStall` is low throughout.
- Changes to the request inputs during ACTIVE have no effect, because the outputs are latched.

## Configuration
- `PIPE_MEMORY_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to ACTIVE and increments each ACTIVE cycle without `memoryReady`.
  - When the count reaches `TIMEOUT_CYCLES`, the block drops `memoryEnable` and goes to DONE. `busError` and `requestDone` pulse together there.
  - `loadData` is unchanged on timeout.
  - If `memoryReady` arrives in the same cycle as the limit, it wins and no error is raised.
- `PIPE_MEMORY_TIMEOUT_EN` undefined: no counter, ACTIVE waits indefinitely, and `busError` is tied 0.

## Test plan
- **Store byte:** `address` = 0x1003, `storeData` = 0xAABBCCDD, `funct3` = 000, ready after 3 cycles → select 1000, `memoryDataWrite` = 0xDD000000, `memoryAddress` = 0x1000, `requestDone` 4 cycles after `memoryEnable` rose.
- **Load half, zero wait:** `address` = 0x2002, `funct3` = 101, `memoryDataRead` = 0x80FF1234, `memoryReady` in first ACTIVE cycle → select 1100, `loadData` = 0x80FF1234, done 2 cycles after accept.
- **Misaligned word:** `address` = 0x3001, `funct3` = 010 → no `memoryEnable`, `addressMisaligned` pulse, `currentPipeStall` stays 0.
- **Back-to-back:** a store then a load, each zero-wait → two distinct `requestDone` pulses. `requestValid` during DONE is ignored, and the second accept lands in the IDLE cycle.
- **Reset mid-ACTIVE:** assert `rst` low → `memoryEnable` 0 without a clock edge; after release the state is IDLE and `loadData` = 0.
- **Timeout** (macro on, `TIMEOUT_CYCLES` = 4): `memoryReady` never asserted → `busError` and `requestDone` pulse together in the cycle after the 4th ACTIVE cycle; `loadData` is unchanged.

Source files
------------

// File: rtl/pipe_memory_request.sv
// pipe_memory_request: single-outstanding load/store initiator with lane select, store alignment and pipe stall.
module pipe_memory_request #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        requestValid,
  input  logic        requestIsStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic        currentPipeStall,
  output logic        requestDone,
  output logic        addressMisaligned,
  output logic        busError,
  output logic [31:0] loadData,
  output logic        memoryEnable,
  output logic        memoryWriteEnable,
  output logic [31:0] memoryAddress,
  output logic [3:0]  memoryByteSelect,
  output logic [31:0] memoryDataWrite,
  input  logic        memoryReady,
  input  logic [31:0] memoryDataRead
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t      r_state, w_next;
  logic [3:0]  w_base;
  logic [6:0]  w_lanes;
  logic [31:0] w_src;
  logic        w_misaligned, w_accept, w_ready, w_timeout, w_unused_funct3;
  logic        r_we, r_mis, r_err;
  logic [31:0] r_addr, r_wdata, r_load;
  logic [3:0]  r_sel;

  assign w_unused_funct3 = funct3[2];
  assign w_base = funct3[1:0] == 2'b00 ? 4'b0001 :
                  funct3[1:0] == 2'b01 ? 4'b0011 :
                  funct3[1:0] == 2'b10 ? 4'b1111 : 4'b0000;
  assign w_lanes = {3'b000, w_base} << address[1:0];
  assign w_misaligned = (w_base == 4'b0000) || |w_lanes[6:4];
  assign w_accept = r_state == IDLE && requestValid && !w_misaligned;
  assign w_ready = r_state == ACTIVE && memoryReady;
  assign w_src = funct3[1:0] == 2'b00 ? {24'd0, storeData[7:0]} :
                 funct3[1:0] == 2'b01 ? {16'd0, storeData[15:0]} : storeData;

`ifdef PIPE_MEMORY_TIMEOUT_EN
  logic [7:0] r_count;
  assign w_timeout = r_state == ACTIVE && !memoryReady && r_count == TIMEOUT_CYCLES - 8'd1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_count <= 8'd0;
    else r_count <= w_accept ? 8'd0 : r_state == ACTIVE ? r_count + 8'd1 : r_count;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? ACTIVE : IDLE;
      ACTIVE:  w_next = (w_ready || w_timeout) ? DONE : ACTIVE;
      default: w_next = IDLE;
    endcase
    currentPipeStall = r_state == ACTIVE || w_accept;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_sel   <= 4'd0;
      r_load  <= 32'd0;
    end else begin
      r_mis <= r_state == IDLE && requestValid && w_misaligned;
      r_err <= w_timeout;
      if (w_accept) begin
        r_we    <= requestIsStore;
        r_addr  <= {address[31:2], 2'b00};
        r_sel   <= w_lanes[3:0];
        r_wdata <= requestIsStore ? w_src << {address[1:0], 3'b000} : 32'd0;
      end
      if (w_ready && !r_we) r_load <= memoryDataRead;
    end

  assign requestDone       = r_state == DONE;
  assign addressMisaligned = r_mis;
  assign busError          = r_err;
  assign loadData          = r_load;
  assign memoryEnable      = r_state == ACTIVE;
  assign memoryWriteEnable = r_we;
  assign memoryAddress     = r_addr;
  assign memoryByteSelect  = r_sel;
  assign memoryDataWrite   = r_wdata;
endmodule

// File: tb/tb_pipe_memory_request.sv
// tb_pipe_memory_request: vector table plus scoreboard queue for the memory request initiator.
module tb_pipe_memory_request;
  logic        clk = 1'b0, rst, requestValid, requestIsStore, memoryReady;
  logic [2:0]  funct3;
  logic [31:0] address, storeData, memoryDataRead;
  logic        currentPipeStall, requestDone, addressMisaligned, busError;
  logic        memoryEnable, memoryWriteEnable;
  logic [31:0] loadData, memoryAddress, memoryDataWrite;
  logic [3:0]  memoryByteSelect;

  typedef struct {
    logic st; logic [2:0] f3; logic [31:0] addr, sd, rd; int wt;
    logic mis; logic [3:0] sel; logic [31:0] wd, maddr;
  } vec_t;
  typedef struct { logic we; logic [3:0] sel; logic [31:0] wd, maddr; } exp_t;

  exp_t        q[$];
  vec_t        tbl[11];
  int          n_chk = 0, n_fail = 0;
  logic [31:0] exp_load = 32'd0;

  always #5 clk = ~clk;

  pipe_memory_request #(.TIMEOUT_CYCLES(8'd4)) dut (
    .clk(clk), .rst(rst), .requestValid(requestValid), .requestIsStore(requestIsStore),
    .funct3(funct3), .address(address), .storeData(storeData),
    .currentPipeStall(currentPipeStall), .requestDone(requestDone),
    .addressMisaligned(addressMisaligned), .busError(busError), .loadData(loadData),
    .memoryEnable(memoryEnable), .memoryWriteEnable(memoryWriteEnable),
    .memoryAddress(memoryAddress), .memoryByteSelect(memoryByteSelect),
    .memoryDataWrite(memoryDataWrite), .memoryReady(memoryReady),
    .memoryDataRead(memoryDataRead));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic present(input vec_t v);
    requestValid = 1'b1; requestIsStore = v.st; funct3 = v.f3;
    address = v.addr; storeData = v.sd;
  endtask

  task automatic run(input vec_t v, input bit linger);
    int cyc;
    logic [3:0] sel;
    logic [31:0] a;
    exp_t e;
    present(v);
    #1;
    chk("stall_present", 32'(currentPipeStall), 32'(!v.mis));
    if (!v.mis) q.push_back('{we: v.st, sel: v.sel, wd: v.wd, maddr: v.maddr});
    @(posedge clk); #1;
    requestValid = 1'b0; address = $urandom; storeData = $urandom;
    funct3 = 3'($urandom); requestIsStore = ~v.st;
    chk("misaligned_pulse", 32'(addressMisaligned), 32'(v.mis));
    chk("enable_after_accept", 32'(memoryEnable), 32'(!v.mis));
    if (v.mis) begin
      chk("misaligned_stall", 32'(currentPipeStall), 32'd0);
      @(posedge clk); #1;
      chk("misaligned_clear", 32'(addressMisaligned), 32'd0);
      chk("misaligned_no_bus", 32'(memoryEnable), 32'd0);
    end else begin
      sel = memoryByteSelect; a = memoryAddress; cyc = 0;
      memoryDataRead = v.rd;
      while (!requestDone && cyc < 20) begin
        if (cyc > 0) begin
          chk("hold_sel", 32'(memoryByteSelect), 32'(sel));
          chk("hold_addr", memoryAddress, a);
          chk("enable_held", 32'(memoryEnable), 32'd1);
        end
        memoryReady = (cyc == v.wt);
        @(posedge clk); #1;
        cyc++;
      end
      memoryReady = 1'b0;
      memoryDataRead = $urandom;
      e = q.pop_front();
      chk("byte_select", 32'(sel), 32'(e.sel));
      chk("word_address", a, e.maddr);
      chk("write_enable", 32'(memoryWriteEnable), 32'(e.we));
      if (e.we) chk("write_data", memoryDataWrite, e.wd);
      chk("done_latency", 32'(cyc), 32'(v.wt + 1));
      chk("enable_dropped", 32'(memoryEnable), 32'd0);
      chk("no_bus_error", 32'(busError), 32'd0);
      if (!v.st) exp_load = v.rd;
      if (linger) begin
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(requestDone), 32'd0);
      end
    end
    chk("load_data", loadData, exp_load);
  endtask

  initial begin
    int cyc;
    tbl[0]  = '{1'b1, 3'b000, 32'h1003, 32'hAABBCCDD, 32'h0,        3, 1'b0, 4'b1000, 32'hDD000000, 32'h1000};
    tbl[1]  = '{1'b0, 3'b101, 32'h2002, 32'h0,        32'h80FF1234, 0, 1'b0, 4'b1100, 32'h0,        32'h2000};
    tbl[2]  = '{1'b0, 3'b010, 32'h3001, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
    tbl[3]  = '{1'b1, 3'b001, 32'h4002, 32'h12345678, 32'h0,        1, 1'b0, 4'b1100, 32'h56780000, 32'h4000};
    tbl[4]  = '{1'b1, 3'b010, 32'h5000, 32'hDEADBEEF, 32'h0,        2, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h5000};
    tbl[5]  = '{1'b1, 3'b001, 32'h6003, 32'h1111,     32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
    tbl[6]  = '{1'b0, 3'b011, 32'h7000, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0};
    tbl[7]  = '{1'b0, 3'b100, 32'h8001, 32'h0,        32'h11223344, 0, 1'b0, 4'b0010, 32'h0,        32'h8000};
    tbl[8]  = '{1'b0, 3'b010, 32'h9000, 32'h0,        32'hCAFEF00D, 1, 1'b0, 4'b1111, 32'h0,        32'h9000};
    tbl[9]  = '{1'b1, 3'b000, 32'hA001, 32'hFFFFFF5A, 32'h0,        0, 1'b0, 4'b0010, 32'h00005A00, 32'hA000};
    tbl[10] = '{1'b1, 3'b001, 32'hB001, 32'h1234BEEF, 32'h0,        2, 1'b0, 4'b0110, 32'h00BEEF00, 32'hB000};
    rst = 1'b0; requestValid = 1'b0; requestIsStore = 1'b0; funct3 = 3'd0;
    address = 32'd0; storeData = 32'd0; memoryReady = 1'b0; memoryDataRead = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_enable", 32'(memoryEnable), 32'd0);
    chk("reset_stall", 32'(currentPipeStall), 32'd0);
    chk("reset_done", 32'(requestDone), 32'd0);
    chk("reset_misaligned", 32'(addressMisaligned), 32'd0);
    chk("reset_bus_error", 32'(busError), 32'd0);
    chk("reset_load_data", loadData, 32'd0);
    chk("reset_address", memoryAddress, 32'd0);
    chk("reset_select", 32'(memoryByteSelect), 32'd0);
    chk("reset_write_data", memoryDataWrite, 32'd0);
    chk("reset_write_enable", 32'(memoryWriteEnable), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    memoryReady = 1'b1; memoryDataRead = 32'hFFFFFFFF;
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_ready_no_done", 32'(requestDone), 32'd0);
      chk("idle_ready_no_enable", 32'(memoryEnable), 32'd0);
    end
    memoryReady = 1'b0;
    chk("idle_ready_load_data", loadData, exp_load);
    for (int i = 0; i < 11; i++) run(tbl[i], 1'b1);
    run(tbl[4], 1'b0);
    present(tbl[1]);
    #1;
    chk("done_ignores_valid", 32'(currentPipeStall), 32'd0);
    @(posedge clk); #1;
    chk("b2b_idle_no_enable", 32'(memoryEnable), 32'd0);
    chk("b2b_done_gap", 32'(requestDone), 32'd0);
    chk("b2b_idle_stall", 32'(currentPipeStall), 32'd1);
    run(tbl[1], 1'b1);
    present(tbl[8]);
    @(posedge clk); #1;
    requestValid = 1'b0;
    chk("pre_reset_enable", 32'(memoryEnable), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_reset_enable", 32'(memoryEnable), 32'd0);
    chk("async_reset_load_data", loadData, 32'd0);
    exp_load = 32'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", 32'(memoryEnable), 32'd0);
    run(tbl[9], 1'b1);
    run(tbl[7], 1'b1);
`ifdef PIPE_MEMORY_TIMEOUT_EN
    present(tbl[8]);
    @(posedge clk); #1;
    requestValid = 1'b0; cyc = 0;
    memoryDataRead = 32'h5555AAAA;
    while (!requestDone && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("timeout_active_cycles", 32'(cyc), 32'd4);
    chk("timeout_bus_error", 32'(busError), 32'd1);
    chk("timeout_enable", 32'(memoryEnable), 32'd0);
    chk("timeout_load_data", loadData, exp_load);
    @(posedge clk); #1;
    chk("timeout_error_clear", 32'(busError), 32'd0);
    chk("timeout_done_clear", 32'(requestDone), 32'd0);
    run(tbl[0], 1'b1);
`else
    present(tbl[8]);
    @(posedge clk); #1;
    requestValid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("no_timeout_enable", 32'(memoryEnable), 32'd1);
    chk("no_timeout_done", 32'(requestDone), 32'd0);
    memoryReady = 1'b1; memoryDataRead = 32'h0BADF00D;
    @(posedge clk); #1;
    memoryReady = 1'b0;
    chk("late_ready_done", 32'(requestDone), 32'd1);
    chk("late_ready_error", 32'(busError), 32'd0);
    chk("late_ready_load", loadData, 32'h0BADF00D);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
